// File: rtl/match_engine_p.sv
// Nearest/second-nearest SAD matcher: sweeps image groups against all target words,
// keeping running {idx, best, second} per target keypoint in an external match RAM.
module match_engine_p #(
  parameter int T_LANES    = 4,
  parameter int I_LANES    = 4,
  parameter int DESC_BYTES = 128,
  parameter int ADDR_W     = 9,
  parameter int IDX_W      = 11,
  parameter int DIST_W     = 16,
  localparam int DESC_W    = 8 * DESC_BYTES,
  localparam int ENT_W     = IDX_W + 2 * DIST_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       abort,
  input  logic [IDX_W-1:0]           img_kpt_num,
  input  logic [IDX_W-1:0]           tar_kpt_num,
  output logic                       busy,
  output logic                       done,
  output logic                       img_req,
  input  logic                       img_valid,
  input  logic [I_LANES*DESC_W-1:0]  img_desc,
  output logic [ADDR_W-1:0]          tar_addr,
  input  logic [T_LANES*DESC_W-1:0]  tar_rdata,
  input  logic [T_LANES*ENT_W-1:0]   mem_rdata,
  output logic [ADDR_W-1:0]          mem_waddr,
  output logic [T_LANES-1:0]         mem_we,
  output logic [T_LANES*ENT_W-1:0]   mem_wdata
);

  localparam logic [31:0] DMAX = 32'((64'd1 << DIST_W) - 64'd1);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_SCAN, S_DRAIN, S_DONE} state_t;

  state_t                     state_q, state_d;
  logic [IDX_W-1:0]           img_n_q, img_n_d;
  logic [IDX_W-1:0]           tar_n_q, tar_n_d;
  logic [IDX_W-1:0]           ig_q, ig_d;
  logic [IDX_W-1:0]           tg_q, tg_d;
  logic [IDX_W-1:0]           g_q, g_d;
  logic [ADDR_W-1:0]          addr_q, addr_d;
  logic                       drain_q, drain_d;
  logic [I_LANES*DESC_W-1:0]  img_q, img_d;
  logic                       s1_v_q, s1_v_d;
  logic [ADDR_W-1:0]          s1_addr_q, s1_addr_d;
  logic                       s2_v_q, s2_v_d;
  logic [ADDR_W-1:0]          s2_addr_q, s2_addr_d;
  logic [T_LANES*DESC_W-1:0]  tar_q, tar_d;
  logic [T_LANES*ENT_W-1:0]   mem_q, mem_d;

  logic [IDX_W-1:0]           ig_calc, tg_calc;

  function automatic logic [DIST_W-1:0] sad(input logic [DESC_W-1:0] a,
                                            input logic [DESC_W-1:0] b);
    logic [31:0] acc;
    acc = '0;
    for (int unsigned k = 0; k < DESC_BYTES; k++) begin
      if (a[k*8 +: 8] > b[k*8 +: 8]) acc += 32'(a[k*8 +: 8] - b[k*8 +: 8]);
      else                           acc += 32'(b[k*8 +: 8] - a[k*8 +: 8]);
    end
    if (acc > DMAX) return '1;
    return DIST_W'(acc);
  endfunction

  // Strict '<' gives the stored entry and lower lanes priority on ties.
  function automatic logic [ENT_W-1:0] update_entry(
    input logic [ENT_W-1:0]          stored,
    input logic [DESC_W-1:0]         tar,
    input logic [I_LANES*DESC_W-1:0] imgs,
    input logic [IDX_W-1:0]          grp,
    input logic [IDX_W-1:0]          img_n
  );
    logic [IDX_W-1:0]  idx;
    logic [DIST_W-1:0] best, second, d;
    if (grp == '0) begin
      idx    = '0;
      best   = '1;
      second = '1;
    end else begin
      {idx, best, second} = stored;
    end
    for (int unsigned i = 0; i < I_LANES; i++) begin
      if (32'(grp) * I_LANES + i < 32'(img_n)) d = sad(imgs[i*DESC_W +: DESC_W], tar);
      else                                     d = '1;
      if (d < best) begin
        second = best;
        best   = d;
        idx    = IDX_W'(32'(grp) * I_LANES + i);
      end else if (d < second) begin
        second = d;
      end
    end
    return {idx, best, second};
  endfunction

  assign ig_calc = IDX_W'((32'(img_kpt_num) + I_LANES - 1) / I_LANES);
  assign tg_calc = IDX_W'((32'(tar_kpt_num) + T_LANES - 1) / T_LANES);

  always_comb begin
    state_d   = state_q;
    img_n_d   = img_n_q;
    tar_n_d   = tar_n_q;
    ig_d      = ig_q;
    tg_d      = tg_q;
    g_d       = g_q;
    addr_d    = addr_q;
    drain_d   = drain_q;
    img_d     = img_q;
    s1_v_d    = 1'b0;
    s1_addr_d = addr_q;
    s2_v_d    = s1_v_q;
    s2_addr_d = s1_addr_q;
    tar_d     = tar_rdata;
    mem_d     = mem_rdata;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          img_n_d = img_kpt_num;
          tar_n_d = tar_kpt_num;
          ig_d    = ig_calc;
          tg_d    = tg_calc;
          g_d     = '0;
          addr_d  = '0;
          state_d = (ig_calc == '0 || tg_calc == '0) ? S_DONE : S_REQ;
        end
      end
      S_REQ: begin
        if (img_valid) begin
          img_d   = img_desc;
          addr_d  = '0;
          state_d = S_SCAN;
        end
      end
      S_SCAN: begin
        s1_v_d = 1'b1;
        if (32'(addr_q) + 1 == 32'(tg_q)) begin
          addr_d  = '0;
          drain_d = 1'b0;
          state_d = S_DRAIN;
        end else begin
          addr_d = addr_q + 1'b1;
        end
      end
      S_DRAIN: begin
        if (drain_q) begin
          drain_d = 1'b0;
          if (32'(g_q) + 1 < 32'(ig_q)) begin
            g_d     = g_q + 1'b1;
            state_d = S_REQ;
          end else begin
            state_d = S_DONE;
          end
        end else begin
          drain_d = 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (abort) begin
      state_d = S_IDLE;
      addr_d  = '0;
      drain_d = 1'b0;
      s1_v_d  = 1'b0;
      s2_v_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      img_n_q   <= '0;
      tar_n_q   <= '0;
      ig_q      <= '0;
      tg_q      <= '0;
      g_q       <= '0;
      addr_q    <= '0;
      drain_q   <= 1'b0;
      img_q     <= '0;
      s1_v_q    <= 1'b0;
      s1_addr_q <= '0;
      s2_v_q    <= 1'b0;
      s2_addr_q <= '0;
      tar_q     <= '0;
      mem_q     <= '0;
    end else begin
      state_q   <= state_d;
      img_n_q   <= img_n_d;
      tar_n_q   <= tar_n_d;
      ig_q      <= ig_d;
      tg_q      <= tg_d;
      g_q       <= g_d;
      addr_q    <= addr_d;
      drain_q   <= drain_d;
      img_q     <= img_d;
      s1_v_q    <= s1_v_d;
      s1_addr_q <= s1_addr_d;
      s2_v_q    <= s2_v_d;
      s2_addr_q <= s2_addr_d;
      tar_q     <= tar_d;
      mem_q     <= mem_d;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign img_req   = (state_q == S_REQ);
  assign tar_addr  = addr_q;
  assign mem_waddr = s2_addr_q;

  always_comb begin
    mem_we    = '0;
    mem_wdata = '0;
    for (int unsigned j = 0; j < T_LANES; j++) begin
      mem_we[j] = s2_v_q && !abort && (32'(s2_addr_q) * T_LANES + j < 32'(tar_n_q));
      mem_wdata[j*ENT_W +: ENT_W] = update_entry(mem_q[j*ENT_W +: ENT_W],
                                                 tar_q[j*DESC_W +: DESC_W],
                                                 img_q, g_q, img_n_q);
    end
  end

endmodule

// File: tb/tb_match_engine_p.sv
// Randomised bench for match_engine_p: RAM models plus a brute-force nearest/second-nearest reference.
module tb_match_engine_p;

  localparam int TL     = 4;
  localparam int IL     = 4;
  localparam int DB     = 32;
  localparam int AW     = 9;
  localparam int IW     = 11;
  localparam int DW     = 11;
  localparam int DESC_W = 8 * DB;
  localparam int ENT_W  = IW + 2 * DW;
  localparam int DMAX   = (1 << DW) - 1;
  localparam int NK     = 64;

  logic                    clk = 1'b0;
  logic                    rst, start, abort, img_valid;
  logic [IW-1:0]           img_kpt_num, tar_kpt_num;
  logic                    busy, done, img_req;
  logic [IL*DESC_W-1:0]    img_desc;
  logic [AW-1:0]           tar_addr, mem_waddr;
  logic [TL*DESC_W-1:0]    tar_rdata;
  logic [TL*ENT_W-1:0]     mem_rdata, mem_wdata;
  logic [TL-1:0]           mem_we;

  logic [DESC_W-1:0]       tar_kd  [NK];
  logic [DESC_W-1:0]       img_kd  [NK];
  logic [TL*ENT_W-1:0]     match_ram [512];
  logic [TL*ENT_W-1:0]     garbage   [512];
  int                      wr_cnt  [512];
  logic [TL-1:0]           last_we [512];
  int                      run_id = 0;
  int                      req_delay = 0;
  int                      n_vec = 0;
  int                      n_err = 0;

  match_engine_p #(
    .T_LANES(TL), .I_LANES(IL), .DESC_BYTES(DB), .ADDR_W(AW), .IDX_W(IW), .DIST_W(DW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .img_kpt_num(img_kpt_num), .tar_kpt_num(tar_kpt_num),
    .busy(busy), .done(done), .img_req(img_req), .img_valid(img_valid),
    .img_desc(img_desc), .tar_addr(tar_addr), .tar_rdata(tar_rdata),
    .mem_rdata(mem_rdata), .mem_waddr(mem_waddr), .mem_we(mem_we), .mem_wdata(mem_wdata)
  );

  always #5 clk = ~clk;

  // Target RAM and match RAM, 1-cycle read latency; match RAM reloaded with garbage per run.
  int ram_run = -1;
  always @(posedge clk) begin
    if (ram_run != run_id) begin
      ram_run = run_id;
      for (int a = 0; a < 512; a++) match_ram[a] <= garbage[a];
    end else begin
      for (int j = 0; j < TL; j++)
        if (mem_we[j]) match_ram[mem_waddr][j*ENT_W +: ENT_W] <= mem_wdata[j*ENT_W +: ENT_W];
    end
    for (int j = 0; j < TL; j++)
      tar_rdata[j*DESC_W +: DESC_W] <= tar_kd[(int'(tar_addr) * TL + j) % NK];
    mem_rdata <= match_ram[tar_addr];
  end

  // Image group source: answers each request after req_delay cycles with a one-cycle pulse.
  initial begin
    int drv_run, grp, wcnt;
    drv_run = -1; grp = 0; wcnt = 0;
    img_valid = 1'b0;
    img_desc  = '0;
    forever begin
      @(negedge clk);
      if (drv_run != run_id) begin
        drv_run = run_id; grp = 0; wcnt = 0;
      end
      if (img_valid) begin
        img_valid = 1'b0;
        grp++;
      end else if (img_req) begin
        if (wcnt >= req_delay) begin
          for (int i = 0; i < IL; i++) img_desc[i*DESC_W +: DESC_W] = img_kd[(grp * IL + i) % NK];
          img_valid = 1'b1;
          wcnt = 0;
        end else begin
          wcnt++;
        end
      end
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int sad_ref(input logic [DESC_W-1:0] a, input logic [DESC_W-1:0] b);
    int s = 0;
    for (int k = 0; k < DB; k++) begin
      int x = int'(a[k*8 +: 8]);
      int y = int'(b[k*8 +: 8]);
      s += (x > y) ? x - y : y - x;
    end
    return (s > DMAX) ? DMAX : s;
  endfunction

  // Nearest = smallest distance (lowest index on ties); second = next smallest of the rest.
  function automatic logic [ENT_W-1:0] ref_entry(input int k, input int img_n);
    int d [NK];
    int bestd = DMAX + 1;
    int idx = 0;
    int sec = DMAX;
    for (int m = 0; m < img_n; m++) begin
      d[m] = sad_ref(img_kd[m], tar_kd[k]);
      if (d[m] < bestd) begin bestd = d[m]; idx = m; end
    end
    for (int m = 0; m < img_n; m++)
      if (m != idx && d[m] < sec) sec = d[m];
    return {IW'(idx), DW'(bestd), DW'(sec)};
  endfunction

  function automatic logic [DESC_W-1:0] rand_desc(input int maxv);
    logic [DESC_W-1:0] v;
    for (int b = 0; b < DB; b++) v[b*8 +: 8] = 8'($urandom_range(maxv, 0));
    return v;
  endfunction

  task automatic fill_rand(input int maxv);
    for (int k = 0; k < NK; k++) begin
      tar_kd[k] = rand_desc(maxv);
      img_kd[k] = rand_desc(maxv);
    end
    for (int a = 0; a < 512; a++)
      for (int j = 0; j < TL; j++)
        garbage[a][j*ENT_W +: ENT_W] = ENT_W'({$urandom, $urandom});
  endtask

  task automatic run_case(input int img_n, input int tar_n, input int dly, input int abort_grp);
    int ig, tg, cyc, done_cyc, last_wr, wr_cycles, req_cyc, bad_addr, max_addr, groups, stray;
    int late_we, late_done;
    logic finished, prev_req;
    ig = (img_n + IL - 1) / IL;
    tg = (tar_n + TL - 1) / TL;
    cyc = 0; done_cyc = -1; last_wr = -1; wr_cycles = 0; req_cyc = 0;
    bad_addr = 0; max_addr = 0; groups = 0; stray = 0;
    finished = 1'b0; prev_req = 1'b0;
    for (int a = 0; a < 512; a++) begin wr_cnt[a] = 0; last_we[a] = '0; end
    req_delay = dly;
    @(negedge clk);
    run_id++;
    @(negedge clk);
    img_kpt_num = IW'(img_n);
    tar_kpt_num = IW'(tar_n);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (!finished && cyc < 4000) begin
      cyc++;
      if (mem_we != '0) begin
        wr_cnt[mem_waddr]++;
        last_we[mem_waddr] = mem_we;
        last_wr = cyc;
        wr_cycles++;
      end
      if (img_req) begin
        req_cyc++;
        if (tar_addr != '0) bad_addr++;
      end
      if (int'(tar_addr) > max_addr) max_addr = int'(tar_addr);
      if (prev_req && !img_req) groups++;
      prev_req = img_req;
      if (done) begin
        done_cyc = cyc;
        finished = 1'b1;
      end else if (abort_grp != 0 && groups == abort_grp) begin
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check_eq("abort_busy", busy, 1'b0);
        late_we = 0; late_done = 0;
        for (int c = 0; c < 30; c++) begin
          if (mem_we != '0) late_we++;
          if (done) late_done++;
          @(negedge clk);
        end
        check_eq("abort_no_we", late_we, 0);
        check_eq("abort_no_done", late_done, 0);
        check_eq("abort_idle", busy, 1'b0);
        return;
      end
      if (!finished) @(negedge clk);
    end
    check_eq("run_done", finished, 1'b1);
    @(negedge clk);
    check_eq("post_idle", busy, 1'b0);
    if (ig == 0 || tg == 0) begin
      check_eq("zero_done_cyc", done_cyc, 1);
      check_eq("zero_writes", wr_cycles, 0);
      check_eq("zero_req", req_cyc, 0);
      return;
    end
    check_eq("done_cyc", done_cyc, ig * (dly + 1 + tg + 2) + 1);
    check_eq("done_after_wr", done_cyc, last_wr + 1);
    check_eq("req_cycles", req_cyc, ig * (dly + 1));
    check_eq("req_addr_idle", bad_addr, 0);
    check_eq("wr_cycles", wr_cycles, ig * tg);
    check_eq("max_addr", max_addr, tg - 1);
    for (int a = tg; a < 512; a++) stray += wr_cnt[a];
    check_eq("stray_writes", stray, 0);
    for (int a = 0; a < tg; a++) begin
      check_eq($sformatf("wr_cnt a%0d", a), wr_cnt[a], ig);
      for (int j = 0; j < TL; j++) begin
        int k = a * TL + j;
        if (k < tar_n)
          check_eq($sformatf("entry k%0d", k), match_ram[a][j*ENT_W +: ENT_W], ref_entry(k, img_n));
        else
          check_eq($sformatf("untouched k%0d", k), match_ram[a][j*ENT_W +: ENT_W],
                   garbage[a][j*ENT_W +: ENT_W]);
      end
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    img_kpt_num = '0; tar_kpt_num = '0;
    fill_rand(255);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_done", done, 1'b0);
    check_eq("rst_req", img_req, 1'b0);
    check_eq("rst_we", mem_we, '0);
    check_eq("rst_taddr", tar_addr, '0);
    check_eq("rst_waddr", mem_waddr, '0);

    // Exact match on image 2 against zero-valued neighbours.
    fill_rand(15);
    for (int k = 0; k < NK; k++) img_kd[k] = '0;
    img_kd[2] = tar_kd[0];
    run_case(4, 4, 0, 0);

    fill_rand(255);
    run_case(6, 8, 1, 0);

    fill_rand(15);
    run_case(4, 5, 0, 0);
    check_eq("we_addr1", last_we[1], 4'b0001);

    // Images 1 and 5 tie at distance 10; all others saturate.
    fill_rand(15);
    tar_kd[0] = '0;
    for (int k = 0; k < NK; k++)
      for (int b = 0; b < DB; b++) img_kd[k][b*8 +: 8] = 8'd100;
    img_kd[1] = '0; img_kd[1][7:0] = 8'd10;
    img_kd[5] = '0; img_kd[5][7:0] = 8'd10;
    run_case(8, 1, 0, 0);
    check_eq("tie_entry", match_ram[0][0 +: ENT_W], {IW'(1), DW'(10), DW'(10)});

    run_case(0, 8, 0, 0);
    run_case(5, 0, 0, 0);

    fill_rand(255);
    run_case(12, 16, 0, 2);
    fill_rand(15);
    run_case(12, 16, 0, 0);

    fill_rand(15);
    run_case(8, 8, 7, 0);

    for (int r = 0; r < 12; r++) begin
      fill_rand(($urandom_range(1, 0) == 1) ? 255 : 15);
      run_case(int'($urandom_range(48, 1)), int'($urandom_range(60, 1)),
               int'($urandom_range(3, 0)), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
